// File: rtl/vmcoffee_pkg.sv
// vmcoffee_pkg: shared state encoding, coin values and product pricing for the vending controller.
package vmcoffee_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_BREW, S_CHANGE, S_ERROR} state_t;
  localparam int C5_UNITS  = 1;
  localparam int C10_UNITS = 2;
  function automatic int price(input int id, input int base = 3);
    return base + id;
  endfunction
endpackage

// File: rtl/vmcoffee_multi_if.sv
// vmcoffee_multi_if: coin/NFC front end and brew actuator signals of the vending controller.
interface vmcoffee_multi_if #(parameter int N_PROD = 4, parameter int CREDIT_W = 6);
  localparam int ID_W = $clog2(N_PROD);
  logic c10, c5, nfc, sel_valid, cancel, beans;
  logic [ID_W-1:0] sel_id, prod;
  logic [4:0] water;
  logic coffee, change5, coin_rej, sel_nak, error;
  logic [CREDIT_W-1:0] credit;
  modport master (output c10, c5, nfc, sel_valid, sel_id, cancel, water, beans,
                  input coffee, prod, change5, coin_rej, sel_nak, credit, error);
  modport slave (input c10, c5, nfc, sel_valid, sel_id, cancel, water, beans,
                 output coffee, prod, change5, coin_rej, sel_nak, credit, error);
endinterface

// File: rtl/vm_timer.sv
// vm_timer: down-counter reloaded by restart; expire marks the LEN-th cycle since the last restart.
module vm_timer #(parameter int LEN = 4) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);
  localparam int W = $clog2(LEN + 1);
  logic [W-1:0] cnt;
  assign expire = !restart && cnt == W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= W'(LEN);
    else cnt <= restart || expire ? W'(LEN) : cnt - W'(1);
endmodule

// File: rtl/vmcoffee_multi.sv
// vmcoffee_multi: multi-product coin/NFC coffee vending controller with change return and supply monitoring.
module vmcoffee_multi import vmcoffee_pkg::*; #(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 6,
  parameter int PRICE_BASE = 3,
  parameter int WATER_MIN  = 2,
  parameter int BREW_CYC   = 4,
  parameter int TIMEOUT    = 20
) (
  input logic clk,
  input logic rst,
  vmcoffee_multi_if.slave bus
);
  localparam int ID_W = $clog2(N_PROD);
  state_t state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx, cr_add, pr;
  logic [CREDIT_W:0] sum;
  logic [ID_W-1:0] prod, prod_nx;
  logic [1:0] val;
  logic nfc_ok, nfc_nx, fault, coin, coin_ok, id_ok, accept, quit, to_exp, br_exp;
  logic coffee, change5, coin_rej, sel_nak, error;
  logic coffee_nx, change5_nx, coin_rej_nx, sel_nak_nx, error_nx;
  assign fault   = bus.water < 5'(WATER_MIN) || !bus.beans;
  assign coin    = bus.c10 || bus.c5;
  assign val     = (bus.c10 ? 2'(C10_UNITS) : 2'd0) + (bus.c5 ? 2'(C5_UNITS) : 2'd0);
  assign sum     = {1'b0, credit} + (CREDIT_W+1)'(val);
  assign coin_ok = coin && !sum[CREDIT_W];
  // A coin that would overflow the credit register is bounced whole.
  assign cr_add  = coin_ok ? sum[CREDIT_W-1:0] : credit;
  assign pr      = CREDIT_W'(price(int'(bus.sel_id), PRICE_BASE));
  assign id_ok   = {1'b0, bus.sel_id} < (ID_W+1)'(N_PROD);
  assign accept  = state == S_CREDIT && !fault && !bus.cancel && bus.sel_valid && id_ok && (nfc_ok || credit >= pr);
  assign quit    = fault || bus.cancel || to_exp;
  vm_timer #(.LEN(TIMEOUT)) u_timeout (
    .clk(clk), .rst(rst),
    .restart(state != S_CREDIT || coin || bus.nfc || bus.sel_valid),
    .expire(to_exp)
  );
  vm_timer #(.LEN(BREW_CYC)) u_brew (
    .clk(clk), .rst(rst), .restart(state != S_BREW), .expire(br_exp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      credit   <= '0;
      nfc_ok   <= 1'b0;
      prod     <= '0;
      coffee   <= 1'b0;
      change5  <= 1'b0;
      coin_rej <= 1'b0;
      sel_nak  <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nx;
      credit   <= credit_nx;
      nfc_ok   <= nfc_nx;
      prod     <= prod_nx;
      coffee   <= coffee_nx;
      change5  <= change5_nx;
      coin_rej <= coin_rej_nx;
      sel_nak  <= sel_nak_nx;
      error    <= error_nx;
    end
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    nfc_nx    = nfc_ok;
    case (state)
      S_IDLE:
        if (fault) state_nx = S_ERROR;
        else if (coin || bus.nfc) begin
          state_nx  = S_CREDIT;
          credit_nx = cr_add;
          nfc_nx    = bus.nfc;
        end
      S_CREDIT: begin
        credit_nx = accept && !nfc_ok ? cr_add - pr : cr_add;
        if (quit) begin
          nfc_nx   = 1'b0;
          state_nx = credit_nx != '0 ? S_CHANGE : fault ? S_ERROR : S_IDLE;
        end else if (accept) begin
          nfc_nx   = 1'b0;
          state_nx = S_BREW;
        end else if (bus.nfc) nfc_nx = 1'b1;
      end
      S_BREW: begin
        credit_nx = cr_add;
        if (br_exp) state_nx = cr_add != '0 ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        credit_nx = credit - CREDIT_W'(credit != '0);
        if (credit <= CREDIT_W'(1)) state_nx = fault ? S_ERROR : S_IDLE;
      end
      S_ERROR: if (!fault) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    coffee_nx   = state_nx == S_BREW;
    change5_nx  = state_nx == S_CHANGE;
    error_nx    = state_nx == S_ERROR;
    prod_nx     = accept ? bus.sel_id : state_nx == S_BREW ? prod : '0;
    coin_rej_nx = coin && (state == S_ERROR || state == S_CHANGE || (state == S_IDLE && fault) || !coin_ok);
    sel_nak_nx  = bus.sel_valid && !fault && (state == S_IDLE || (state == S_CREDIT && !bus.cancel && !accept));
  end
  assign bus.coffee   = coffee;
  assign bus.prod     = prod;
  assign bus.change5  = change5;
  assign bus.coin_rej = coin_rej;
  assign bus.sel_nak  = sel_nak;
  assign bus.error    = error;
  assign bus.credit   = credit;
endmodule

// File: tb/tb_vmcoffee_multi.sv
// tb_vmcoffee_multi: directed scenarios for the vending controller with hand-computed expected outputs.
module tb_vmcoffee_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  vmcoffee_multi_if #(.N_PROD(4), .CREDIT_W(6)) bus ();
  vmcoffee_multi dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic cyc(input logic a10, input logic a5, input logic an, input logic sv,
                     input logic [1:0] id, input logic cn);
    bus.c10 = a10;
    bus.c5 = a5;
    bus.nfc = an;
    bus.sel_valid = sv;
    bus.sel_id = id;
    bus.cancel = cn;
    @(negedge clk);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 2'd0, 0);
  endtask
  task automatic expect_o(input string tag, input logic cof, input logic [1:0] pd, input logic ch,
                          input logic cr, input logic nk, input logic er, input logic [5:0] cd);
    logic [12:0] obs, want;
    obs = {bus.coffee, bus.prod, bus.change5, bus.coin_rej, bus.sel_nak, bus.error, bus.credit};
    want = {cof, pd, ch, cr, nk, er, cd};
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed coffee/prod/change5/coin_rej/sel_nak/error/credit=%b expected %b", tag, obs, want);
  endtask
  initial begin
    bus.water = 5'd10;
    bus.beans = 1'b1;
    bus.c10 = 0; bus.c5 = 0; bus.nfc = 0; bus.sel_valid = 0; bus.sel_id = '0; bus.cancel = 0;
    @(negedge clk);
    expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle();
    expect_o("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    expect_o("t1_c10_a", 0, 0, 0, 0, 0, 0, 2);
    cyc(1, 0, 0, 0, 2'd0, 0);
    expect_o("t1_c10_b", 0, 0, 0, 0, 0, 0, 4);
    cyc(0, 0, 0, 1, 2'd1, 0);
    expect_o("t1_brew_1", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      idle();
      expect_o("t1_brew_n", 1, 1, 0, 0, 0, 0, 0);
    end
    idle();
    expect_o("t1_done_no_change", 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    expect_o("t2_credit5", 0, 0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 1, 2'd0, 0);
    expect_o("t2_brew_1", 1, 0, 0, 0, 0, 0, 2);
    repeat (3) idle();
    expect_o("t2_brew_4", 1, 0, 0, 0, 0, 0, 2);
    idle();
    expect_o("t2_change_a", 0, 0, 1, 0, 0, 0, 2);
    idle();
    expect_o("t2_change_b", 0, 0, 1, 0, 0, 0, 1);
    idle();
    expect_o("t2_idle", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    expect_o("t3_credit1", 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 2'd3, 0);
    expect_o("t3_nak", 0, 0, 0, 0, 1, 0, 1);
    repeat (18) idle();
    idle();
    expect_o("t3_quiet20_no_refund_yet", 0, 0, 0, 0, 0, 0, 1);
    idle();
    expect_o("t3_timeout_change", 0, 0, 1, 0, 0, 0, 1);
    idle();
    expect_o("t3_idle", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 0, 2'd0, 1);
    expect_o("cancel_change_a", 0, 0, 1, 0, 0, 0, 2);
    idle();
    expect_o("cancel_change_b", 0, 0, 1, 0, 0, 0, 1);
    idle();
    expect_o("cancel_idle", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 2'd0, 0);
    expect_o("t4_nfc", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd2, 0);
    expect_o("t4_brew_free", 1, 2, 0, 0, 0, 0, 0);
    repeat (3) idle();
    expect_o("t4_brew_4", 1, 2, 0, 0, 0, 0, 0);
    idle();
    expect_o("t4_idle", 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd0, 0);
    expect_o("t4_second_nak", 0, 0, 0, 0, 1, 0, 0);
    bus.water = 5'd1;
    idle();
    expect_o("idle_fault_error", 0, 0, 0, 0, 0, 1, 0);
    bus.water = 5'd10;
    idle();
    expect_o("idle_fault_clear", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 2'd0, 0);
    expect_o("t5_credit6", 0, 0, 0, 0, 0, 0, 6);
    bus.beans = 1'b0;
    idle();
    expect_o("t5_refund_first", 0, 0, 1, 0, 0, 0, 6);
    for (int i = 1; i <= 5; i++) begin
      idle();
      expect_o("t5_refund_n", 0, 0, 1, 0, 0, 0, 6'(6 - i));
    end
    idle();
    expect_o("t5_error", 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    expect_o("t5_coin_rej_err", 0, 0, 0, 1, 0, 1, 0);
    bus.beans = 1'b1;
    idle();
    expect_o("t5_recover", 0, 0, 0, 0, 0, 0, 0);
    repeat (31) cyc(1, 0, 0, 0, 2'd0, 0);
    expect_o("t6_credit62", 0, 0, 0, 0, 0, 0, 62);
    cyc(1, 1, 0, 0, 2'd0, 0);
    expect_o("t6_sat_rej", 0, 0, 0, 1, 0, 0, 62);
    cyc(0, 1, 0, 0, 2'd0, 0);
    expect_o("t6_fill63", 0, 0, 0, 0, 0, 0, 63);
    cyc(0, 1, 0, 0, 2'd0, 0);
    expect_o("t6_full_rej", 0, 0, 0, 1, 0, 0, 63);
    cyc(0, 0, 0, 1, 2'd0, 0);
    expect_o("t6_brew", 1, 0, 0, 0, 0, 0, 60);
    #2 rst = 1'b1;
    #1 expect_o("t6_async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    expect_o("t6_after_rst", 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vmcoffee_multi.md
# vmcoffee_multi

Parametrised multi-product successor to the single-product coffee vending controller. It accumulates coin credit (5 and 10 units) or accepts an NFC authorisation, and dispenses one of `N_PROD` products, each with its own price. It then returns change one coin per cycle and refunds on cancel or inactivity timeout. Water and bean supply are monitored, and the machine blocks with `error` while supply is insufficient. It sits between the coin/NFC front end and the brew actuator.

## Interface
Parameters:
- `N_PROD`, 4 — number of selectable products (≥2).
- `CREDIT_W`, 6 — credit register width, in 5-cent units.
- `PRICE_BASE`, 3 — price of product 0 in 5-cent units; product i costs `PRICE_BASE + i`.
- `WATER_MIN`, 2 — minimum water level required to brew.
- `BREW_CYC`, 4 — cycles `coffee` stays high per cup (≥1).
- `TIMEOUT`, 20 — idle cycles in CREDIT before automatic refund (≥2).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `c10` in 1 — 10-cent coin pulse, adds 2 units.
- `c5` in 1 — 5-cent coin pulse, adds 1 unit.
- `nfc` in 1 — contactless authorisation pulse; grants one free-of-credit selection.
- `sel_valid` in 1 — product selection strobe.
- `sel_id` in `$clog2(N_PROD)` — selected product, sampled with `sel_valid`.
- `cancel` in 1 — refund request.
- `water` in 5 — water level.
- `beans` in 1 — beans present.
- `coffee` out 1 — brew actuator, high for `BREW_CYC` cycles.
- `prod` out `$clog2(N_PROD)` — product being brewed; valid while `coffee`=1.
- `change5` out 1 — one-cycle pulse per returned 5-cent coin.
- `coin_rej` out 1 — coin bounced (error state or credit saturation).
- `sel_nak` out 1 — selection refused (insufficient credit or invalid id).
- `credit` out `CREDIT_W` — current credit.
- `error` out 1 — supply fault.

## Operation
- States: IDLE, CREDIT, BREW, CHANGE, ERROR. The encoding lives in the package.
- Supply fault is defined as `water < WATER_MIN || !beans`, evaluated every cycle.
- **IDLE:**
  - Fault → ERROR.
  - Coin → CREDIT, with credit += value.
  - `nfc` → CREDIT, with the nfc_ok flag set.
- **CREDIT:**
  - Coins accumulate. `c10` and `c5` in the same cycle add 3.
  - If a sum would exceed `2^CREDIT_W-1`, credit is unchanged and `coin_rej` pulses (whole coin(s) rejected).
  - `sel_valid` with `sel_id < N_PROD` and (nfc_ok or credit ≥ price) → BREW.
    - Credit is decremented by the price unless nfc_ok, which then clears.
    - Otherwise `sel_nak` pulses and the state is unchanged.
  - `cancel`, or `TIMEOUT` consecutive cycles without a coin/nfc/sel_valid → CHANGE. nfc_ok clears.
  - A fault in CREDIT → CHANGE (refund first).
  - Priority when events coincide: fault > cancel > sel_valid > coins. Coins arriving in the same cycle as an accepted cancel/sel are still credited.
- **BREW:**
  - `coffee`=1 and `prod` = latched id, for `BREW_CYC` cycles.
  - Coins are accepted and credited. `cancel` and `sel_valid` are ignored.
  - At the end: go to CHANGE if credit>0, else IDLE. Multi-cup credit is not carried over.
  - A fault during BREW does not abort the cup.
- **CHANGE:**
  - One `change5` pulse per cycle, with credit−1 each cycle, until 0.
  - Coins during CHANGE → `coin_rej`.
  - Next state is ERROR on fault, else IDLE.
- **ERROR:**
  - `error`=1. Every coin → `coin_rej`. `nfc` and `sel_valid` are ignored.
  - Leaves to IDLE the first cycle the fault is clear.
- Reset mid-operation: all state is lost, including any unrefunded credit; there is no recovery.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `credit`=0, nfc_ok=0; `coffee`, `prod`, `change5`, `coin_rej`, `sel_nak`, `error` all 0.
- Coin on cycle n → `credit` updated at n+1; `coin_rej`/`sel_nak` pulse at n+1.
- Accepted `sel_valid` at n → `coffee` high n+1 … n+`BREW_CYC`. First `change5` at n+`BREW_CYC`+1 if credit>0.
- Refund of k units takes exactly k cycles of `change5`.
- Fault sampled at n → `error` at n+1 (from IDLE), or after the refund completes (from CREDIT/CHANGE).
- The timeout counter resets on any coin, nfc, or sel_valid (including nak'd). It expires on exactly the `TIMEOUT`-th quiet cycle.

## Structure
- Package `vmcoffee_pkg`: state enum, coin unit constants (`C5_UNITS`=1, `C10_UNITS`=2), price function `price(id)`.
- Sub-module `vm_timer`: loadable down-counter with restart and expire pulse, used for both the timeout and `BREW_CYC`.

## Test plan
- Reset, `water`=10, `beans`=1; `c10`,`c10` then `sel_valid`,`sel_id`=1 (price 4) → `coffee` high 4 cycles, `prod`=1, `credit`=0, no `change5`.
- `c10`,`c10`,`c5` (5 units), select id 0 (price 3) → brew, then 2 `change5` pulses, then IDLE.
- `c5`, select id 3 (price 6) → `sel_nak` pulse, `credit` stays 1; then 20 quiet cycles → 1 `change5`, then IDLE.
- `nfc`, select id 2 → brew with `credit` staying 0; a second select afterwards → `sel_nak`.
- `c10` ×3 (6 units), then `beans`=0 → 6 `change5` pulses, then `error`=1; `c5` → `coin_rej`; `beans`=1 → IDLE next cycle.
- Credit at 62, `c10`+`c5` in the same cycle → `coin_rej`, `credit` stays 62; async `rst` during BREW → all outputs 0 immediately.
